// File: rtl/idx_oh_pkg.sv
// Shared helpers for index <-> one-hot lane bookkeeping: direction codes,
// index decode and popcount over a fixed maximum lane width.
package idx_oh_pkg;

    localparam int          MAX_SIGNALS = 64;
    localparam logic [31:0] DIR_LSB0    = "LSB0";
    localparam logic [31:0] DIR_MSB0    = "MSB0";

    // Out-of-range indices decode to all-zero so they can never mark a lane.
    function automatic logic [MAX_SIGNALS-1:0] idx_to_oh_f(
        input int          index,
        input int          num_signals,
        input logic [31:0] direction
    );
        logic [MAX_SIGNALS-1:0] oh;
        int                     pos;
        oh  = '0;
        pos = (direction == DIR_MSB0) ? (num_signals - 1 - index) : index;
        if ((index >= 0) && (index < num_signals)) begin
            oh = {{(MAX_SIGNALS-1){1'b0}}, 1'b1} << pos;
        end
        return oh;
    endfunction

    function automatic int popcount_f(input logic [MAX_SIGNALS-1:0] vec);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_SIGNALS; i++) begin
            cnt = cnt + {31'b0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/idx_to_oh.sv
// Combinational index to one-hot decoder; zero output on invalid strobe or out-of-range index.
// Latency: none. Backpressure: none.
module idx_to_oh
    import idx_oh_pkg::*;
#(
    parameter int          NUM_SIGNALS = 8,
    parameter logic [31:0] DIRECTION   = DIR_LSB0,
    parameter int          INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
    input  logic                   valid,
    input  logic [INDEX_WIDTH-1:0] index,
    output logic [NUM_SIGNALS-1:0] one_hot
);

    always_comb begin
        one_hot = '0;
        if (valid) begin
            one_hot = NUM_SIGNALS'(idx_to_oh_f(32'(index), NUM_SIGNALS, DIRECTION));
        end
    end

endmodule

// File: rtl/idx_to_oh_tracker.sv
// Pending-lane tracker: set/clr index events into a one-hot mask, drained one lane at a time
// as {one-hot, index}. Latency: set -> pending 1 cycle -> output 1 cycle. Backpressure: output
// holds while out_ready low; pending merges sets. Optional IDX_TO_OH_TRACKER_CHECK_EN adds index_error.
module idx_to_oh_tracker
    import idx_oh_pkg::*;
#(
    parameter int          NUM_SIGNALS = 8,
    parameter logic [31:0] DIRECTION   = DIR_LSB0,
    parameter int          INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_valid,
    input  logic [INDEX_WIDTH-1:0] set_index,
    input  logic                   clr_valid,
    input  logic [INDEX_WIDTH-1:0] clr_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_SIGNALS-1:0] out_one_hot,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic [NUM_SIGNALS-1:0] pending_mask,
    output logic [INDEX_WIDTH:0]   pending_count,
    output logic                   index_error
);

    localparam int CW = INDEX_WIDTH + 1;

    logic [NUM_SIGNALS-1:0] set_oh, clr_oh, load_oh, pick_oh, pend_by_idx;
    logic [NUM_SIGNALS-1:0] pending_q, pending_d;
    logic [INDEX_WIDTH:0]   count_q, count_d;
    logic                   out_valid_q, out_valid_d;
    logic [NUM_SIGNALS-1:0] out_one_hot_q, out_one_hot_d;
    logic [INDEX_WIDTH-1:0] out_index_q, out_index_d;
    logic [INDEX_WIDTH-1:0] pick_idx;
    logic                   found, load;

    idx_to_oh #(.NUM_SIGNALS(NUM_SIGNALS), .DIRECTION(DIRECTION), .INDEX_WIDTH(INDEX_WIDTH)) u_set_dec (
        .valid   (set_valid),
        .index   (set_index),
        .one_hot (set_oh)
    );

    idx_to_oh #(.NUM_SIGNALS(NUM_SIGNALS), .DIRECTION(DIRECTION), .INDEX_WIDTH(INDEX_WIDTH)) u_clr_dec (
        .valid   (clr_valid),
        .index   (clr_index),
        .one_hot (clr_oh)
    );

    // Reorder pending into index order so both directions pick the smallest index.
    always_comb begin
        pend_by_idx = (DIRECTION == DIR_MSB0) ? {<<{pending_q}} : pending_q;
        found       = 1'b0;
        pick_idx    = '0;
        for (int i = NUM_SIGNALS - 1; i >= 0; i--) begin
            if (pend_by_idx[i]) begin
                found    = 1'b1;
                pick_idx = INDEX_WIDTH'(i);
            end
        end
        pick_oh = NUM_SIGNALS'(idx_to_oh_f(32'(pick_idx), NUM_SIGNALS, DIRECTION));
    end

    always_comb begin
        load          = !out_valid_q || out_ready;
        out_valid_d   = out_valid_q;
        out_one_hot_d = out_one_hot_q;
        out_index_d   = out_index_q;
        load_oh       = '0;
        if (load) begin
            out_valid_d = found;
            if (found) begin
                out_one_hot_d = pick_oh;
                out_index_d   = pick_idx;
                load_oh       = pick_oh;
            end
        end
        pending_d = (pending_q & ~clr_oh & ~load_oh) | set_oh;
        count_d   = CW'(popcount_f(MAX_SIGNALS'(pending_d)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q     <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_one_hot_q <= '0;
            out_index_q   <= '0;
        end else begin
            pending_q     <= pending_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_one_hot_q <= out_one_hot_d;
            out_index_q   <= out_index_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_one_hot   = out_one_hot_q;
    assign out_index     = out_index_q;
    assign pending_mask  = pending_q;
    assign pending_count = count_q;

`ifdef IDX_TO_OH_TRACKER_CHECK_EN
    logic index_error_q, index_error_d;
    logic set_bad, clr_bad;

    always_comb begin
        set_bad       = set_valid && (32'(set_index) >= NUM_SIGNALS);
        clr_bad       = clr_valid && (32'(clr_index) >= NUM_SIGNALS);
        index_error_d = index_error_q | set_bad | clr_bad;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_error_q <= 1'b0;
        end else begin
            index_error_q <= index_error_d;
        end
    end

    always @(posedge clk) begin
        if (!reset && (set_bad || clr_bad)) begin
            $error("idx_to_oh_tracker: out-of-range index set=%0d clr=%0d", set_index, clr_index);
        end
    end

    assign index_error = index_error_q;
`else
    assign index_error = 1'b0;
`endif

endmodule

// File: tb/tb_idx_to_oh_tracker.sv
// Directed bench: LSB0 and MSB0 trackers with 8 lanes plus a 6-lane tracker for range handling.
module tb_idx_to_oh_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] set_idx, clr_idx;
    logic       a_sv, a_cv, a_rdy, b_sv, b_cv, b_rdy, c_sv, c_cv, c_rdy;

    logic       a_ov, b_ov, c_ov, a_err, b_err, c_err;
    logic [7:0] a_oh, a_pm, b_oh, b_pm;
    logic [5:0] c_oh, c_pm;
    logic [2:0] a_oi, b_oi, c_oi;
    logic [3:0] a_pc, b_pc, c_pc;

    int passed = 0;
    int total  = 0;

`ifdef IDX_TO_OH_TRACKER_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    idx_to_oh_tracker #(.NUM_SIGNALS(8), .DIRECTION("LSB0")) dut_a (
        .clk(clk), .reset(reset), .set_valid(a_sv), .set_index(set_idx), .clr_valid(a_cv),
        .clr_index(clr_idx), .out_valid(a_ov), .out_ready(a_rdy), .out_one_hot(a_oh),
        .out_index(a_oi), .pending_mask(a_pm), .pending_count(a_pc), .index_error(a_err)
    );

    idx_to_oh_tracker #(.NUM_SIGNALS(8), .DIRECTION("MSB0")) dut_b (
        .clk(clk), .reset(reset), .set_valid(b_sv), .set_index(set_idx), .clr_valid(b_cv),
        .clr_index(clr_idx), .out_valid(b_ov), .out_ready(b_rdy), .out_one_hot(b_oh),
        .out_index(b_oi), .pending_mask(b_pm), .pending_count(b_pc), .index_error(b_err)
    );

    idx_to_oh_tracker #(.NUM_SIGNALS(6), .DIRECTION("LSB0")) dut_c (
        .clk(clk), .reset(reset), .set_valid(c_sv), .set_index(set_idx), .clr_valid(c_cv),
        .clr_index(clr_idx), .out_valid(c_ov), .out_ready(c_rdy), .out_one_hot(c_oh),
        .out_index(c_oi), .pending_mask(c_pm), .pending_count(c_pc), .index_error(c_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_idx = '0; clr_idx = '0;
        a_sv = 0; a_cv = 0; a_rdy = 0;
        b_sv = 0; b_cv = 0; b_rdy = 0;
        c_sv = 0; c_cv = 0; c_rdy = 0;
        tick(); tick();
        total++; if (a_ov !== 1'b0) $display("FAIL rst_valid got %b exp 0", a_ov); else passed++;
        total++; if (a_oh !== 8'h00) $display("FAIL rst_onehot got %h exp 00", a_oh); else passed++;
        total++; if (a_oi !== 3'd0) $display("FAIL rst_index got %0d exp 0", a_oi); else passed++;
        total++; if (a_pm !== 8'h00) $display("FAIL rst_pend got %h exp 00", a_pm); else passed++;
        total++; if (a_pc !== 4'd0) $display("FAIL rst_count got %0d exp 0", a_pc); else passed++;
        total++; if (c_err !== 1'b0) $display("FAIL rst_err got %b exp 0", c_err); else passed++;
        total++; if (b_pm !== 8'h00) $display("FAIL rst_pend_b got %h exp 00", b_pm); else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lsb0_single();
        a_rdy = 1; set_idx = 3'd5; a_sv = 1;
        tick();
        a_sv = 0;
        total++; if (a_pm !== 8'h20) $display("FAIL single_pend got %h exp 20", a_pm); else passed++;
        total++; if (a_pc !== 4'd1) $display("FAIL single_count got %0d exp 1", a_pc); else passed++;
        total++; if (a_ov !== 1'b0) $display("FAIL single_early_valid got %b exp 0", a_ov); else passed++;
        tick();
        total++; if (a_ov !== 1'b1) $display("FAIL single_valid got %b exp 1", a_ov); else passed++;
        total++; if (a_oh !== 8'h20) $display("FAIL single_onehot got %h exp 20", a_oh); else passed++;
        total++; if (a_oi !== 3'd5) $display("FAIL single_index got %0d exp 5", a_oi); else passed++;
        total++; if (a_pm !== 8'h00) $display("FAIL single_pend_drained got %h exp 00", a_pm); else passed++;
        tick();
        total++; if (a_ov !== 1'b0) $display("FAIL single_popped got %b exp 0", a_ov); else passed++;
    endtask

    task automatic test_hold_and_drain();
        a_rdy = 0;
        set_idx = 3'd1; a_sv = 1; tick();
        set_idx = 3'd3; tick();
        set_idx = 3'd6; tick();
        a_sv = 0;
        total++; if (a_pm !== 8'h48) $display("FAIL hold_pend got %h exp 48", a_pm); else passed++;
        total++; if (a_pc !== 4'd2) $display("FAIL hold_count got %0d exp 2", a_pc); else passed++;
        total++; if (a_oi !== 3'd1 || a_oh !== 8'h02) $display("FAIL hold_out got %0d/%h exp 1/02", a_oi, a_oh); else passed++;
        tick(); tick();
        total++; if (a_ov !== 1'b1 || a_oi !== 3'd1) $display("FAIL hold_stable got %b/%0d exp 1/1", a_ov, a_oi); else passed++;
        a_rdy = 1;
        tick();
        total++; if (a_oi !== 3'd3 || a_oh !== 8'h08 || a_pm !== 8'h40) $display("FAIL drain_1 got %0d/%h/%h exp 3/08/40", a_oi, a_oh, a_pm); else passed++;
        tick();
        total++; if (a_oi !== 3'd6 || a_oh !== 8'h40 || a_pm !== 8'h00) $display("FAIL drain_2 got %0d/%h/%h exp 6/40/00", a_oi, a_oh, a_pm); else passed++;
        total++; if (a_pc !== 4'd0) $display("FAIL drain_count got %0d exp 0", a_pc); else passed++;
        tick();
        total++; if (a_ov !== 1'b0) $display("FAIL drain_empty got %b exp 0", a_ov); else passed++;
        a_rdy = 0;
    endtask

    task automatic test_set_clr_same();
        a_rdy = 0;
        set_idx = 3'd0; a_sv = 1; tick();
        a_sv = 0; tick();
        set_idx = 3'd2; clr_idx = 3'd2; a_sv = 1; a_cv = 1; tick();
        a_sv = 0; a_cv = 0;
        total++; if (a_pm !== 8'h04 || a_pc !== 4'd1) $display("FAIL setclr_same got %h/%0d exp 04/1", a_pm, a_pc); else passed++;
        a_cv = 1; tick();
        a_cv = 0;
        total++; if (a_pm !== 8'h00 || a_pc !== 4'd0) $display("FAIL clr_only got %h/%0d exp 00/0", a_pm, a_pc); else passed++;
        clr_idx = 3'd0; a_cv = 1; tick();
        a_cv = 0;
        total++; if (a_ov !== 1'b1 || a_oi !== 3'd0) $display("FAIL clr_out_stage got %b/%0d exp 1/0", a_ov, a_oi); else passed++;
        set_idx = 3'd0; a_sv = 1; tick();
        a_sv = 0;
        total++; if (a_pm !== 8'h01) $display("FAIL reenter_pend got %h exp 01", a_pm); else passed++;
        a_rdy = 1; tick();
        total++; if (a_ov !== 1'b1 || a_oi !== 3'd0 || a_pm !== 8'h00) $display("FAIL reenter_load got %b/%0d/%h exp 1/0/00", a_ov, a_oi, a_pm); else passed++;
        tick();
        total++; if (a_ov !== 1'b0) $display("FAIL reenter_empty got %b exp 0", a_ov); else passed++;
        a_rdy = 0;
    endtask

    task automatic test_msb0();
        b_rdy = 1; set_idx = 3'd0; b_sv = 1; tick();
        b_sv = 0;
        total++; if (b_pm !== 8'h80) $display("FAIL msb0_pend got %h exp 80", b_pm); else passed++;
        tick();
        total++; if (b_ov !== 1'b1 || b_oh !== 8'h80 || b_oi !== 3'd0) $display("FAIL msb0_out got %b/%h/%0d exp 1/80/0", b_ov, b_oh, b_oi); else passed++;
        tick();
        b_rdy = 0;
        set_idx = 3'd3; b_sv = 1; tick();
        b_sv = 0; tick();
        total++; if (b_oi !== 3'd3 || b_oh !== 8'h10) $display("FAIL msb0_idx3 got %0d/%h exp 3/10", b_oi, b_oh); else passed++;
        set_idx = 3'd7; b_sv = 1; tick();
        set_idx = 3'd0; tick();
        b_sv = 0;
        total++; if (b_pm !== 8'h81 || b_pc !== 4'd2) $display("FAIL msb0_pend2 got %h/%0d exp 81/2", b_pm, b_pc); else passed++;
        b_rdy = 1; tick();
        total++; if (b_oi !== 3'd0 || b_oh !== 8'h80 || b_pm !== 8'h01) $display("FAIL msb0_first got %0d/%h/%h exp 0/80/01", b_oi, b_oh, b_pm); else passed++;
        tick();
        total++; if (b_oi !== 3'd7 || b_oh !== 8'h01 || b_pm !== 8'h00) $display("FAIL msb0_second got %0d/%h/%h exp 7/01/00", b_oi, b_oh, b_pm); else passed++;
        tick();
        total++; if (b_ov !== 1'b0) $display("FAIL msb0_empty got %b exp 0", b_ov); else passed++;
        b_rdy = 0;
    endtask

    task automatic test_full_and_reset();
        a_rdy = 0; a_sv = 1;
        for (int i = 0; i < 8; i++) begin
            set_idx = 3'(i);
            tick();
        end
        total++; if (a_pm !== 8'hFE || a_pc !== 4'd7) $display("FAIL full_pre got %h/%0d exp FE/7", a_pm, a_pc); else passed++;
        set_idx = 3'd0; tick();
        total++; if (a_pm !== 8'hFF || a_pc !== 4'd8) $display("FAIL full got %h/%0d exp FF/8", a_pm, a_pc); else passed++;
        set_idx = 3'd3; tick();
        a_sv = 0;
        total++; if (a_pm !== 8'hFF || a_pc !== 4'd8 || a_ov !== 1'b1) $display("FAIL full_merge got %h/%0d/%b exp FF/8/1", a_pm, a_pc, a_ov); else passed++;
        reset = 1'b1;
        #1;
        total++; if (a_ov !== 1'b0 || a_oh !== 8'h00 || a_oi !== 3'd0) $display("FAIL async_rst_out got %b/%h/%0d exp 0/00/0", a_ov, a_oh, a_oi); else passed++;
        total++; if (a_pm !== 8'h00 || a_pc !== 4'd0) $display("FAIL async_rst_pend got %h/%0d exp 00/0", a_pm, a_pc); else passed++;
        #1;
        reset = 1'b0;
        tick();
        total++; if (a_pm !== 8'h00 || a_ov !== 1'b0) $display("FAIL post_rst got %h/%b exp 00/0", a_pm, a_ov); else passed++;
    endtask

    task automatic test_range();
        c_rdy = 0;
        set_idx = 3'd7; c_sv = 1; tick();
        c_sv = 0;
        total++; if (c_pm !== 6'h00 || c_pc !== 4'd0) $display("FAIL range_ignored got %h/%0d exp 00/0", c_pm, c_pc); else passed++;
        total++; if (c_err !== EXP_ERR) $display("FAIL range_err got %b exp %b", c_err, EXP_ERR); else passed++;
        set_idx = 3'd6; c_sv = 1; tick();
        c_sv = 0;
        total++; if (c_pm !== 6'h00) $display("FAIL range_idx6 got %h exp 00", c_pm); else passed++;
        set_idx = 3'd5; c_sv = 1; tick();
        c_sv = 0;
        total++; if (c_pm !== 6'h20 || c_pc !== 4'd1) $display("FAIL range_valid got %h/%0d exp 20/1", c_pm, c_pc); else passed++;
        tick();
        total++; if (c_ov !== 1'b1 || c_oi !== 3'd5 || c_oh !== 6'h20) $display("FAIL range_out got %b/%0d/%h exp 1/5/20", c_ov, c_oi, c_oh); else passed++;
        total++; if (c_err !== EXP_ERR) $display("FAIL range_err_sticky got %b exp %b", c_err, EXP_ERR); else passed++;
        total++; if (a_err !== 1'b0) $display("FAIL err_other got %b exp 0", a_err); else passed++;
    endtask

    initial begin
        test_reset();
        test_lsb0_single();
        test_hold_and_drain();
        test_set_clr_same();
        test_msb0();
        test_full_and_reset();
        test_range();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
